qhy_rotate: RTL and testbench



---
 rtl/qhy_rotate.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_qhy_rotate.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qhy_rotate.sv
// Rotates received 2-element complex vectors by the latched Q^H matrix (z = Q^H * y)
// using a single time-shared complex multiplier; z0 and z1 are streamed out serially.
module qhy_rotate #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qh_valid,
  input  logic [WIDTH-1:0] q_H_00_re,
  input  logic [WIDTH-1:0] q_H_00_im,
  input  logic [WIDTH-1:0] q_H_01_re,
  input  logic [WIDTH-1:0] q_H_01_im,
  input  logic [WIDTH-1:0] q_H_10_re,
  input  logic [WIDTH-1:0] q_H_10_im,
  input  logic [WIDTH-1:0] q_H_11_re,
  input  logic [WIDTH-1:0] q_H_11_im,
  input  logic [WIDTH-1:0] y_re,
  input  logic [WIDTH-1:0] y_im,
  input  logic             y_valid,
  output logic             y_ready,
  output logic [WIDTH-1:0] z_re,
  output logic [WIDTH-1:0] z_im,
  output logic             z_idx,
  output logic             z_valid
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_Y0,
    S_WAIT_Y1,
    S_MAC,
    S_OUT0,
    S_OUT1
  } state_t;

  state_t state_q, state_d;

  logic [1:0] cnt_q, cnt_d;
  logic       qh_valid_prev_q, qh_valid_prev_d;
  logic       pend_q, pend_d;
  logic       qh_load_req;
  logic       load_en;
  logic       y_xfer;

  logic [WIDTH-1:0]        qh_in_re [4];
  logic [WIDTH-1:0]        qh_in_im [4];
  logic signed [WIDTH-1:0] qh_re [4];
  logic signed [WIDTH-1:0] qh_im [4];

  logic signed [WIDTH-1:0] y0_re_q, y0_re_d, y0_im_q, y0_im_d;
  logic signed [WIDTH-1:0] y1_re_q, y1_re_d, y1_im_q, y1_im_d;

  logic signed [AW-1:0] acc0_re_q, acc0_re_d, acc0_im_q, acc0_im_d;
  logic signed [AW-1:0] acc1_re_q, acc1_re_d, acc1_im_q, acc1_im_d;

  logic signed [WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;
  logic                    z_idx_q, z_idx_d;
  logic                    z_valid_q, z_valid_d;

  logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
  logic signed [PW-1:0]    p_ac, p_bd, p_ad, p_bc;
  logic signed [AW-1:0]    prod_re, prod_im;

  // Entry order 0..3 = q00, q01, q10, q11, which is also the MAC step order.
  assign qh_in_re[0] = q_H_00_re;
  assign qh_in_im[0] = q_H_00_im;
  assign qh_in_re[1] = q_H_01_re;
  assign qh_in_im[1] = q_H_01_im;
  assign qh_in_re[2] = q_H_10_re;
  assign qh_in_im[2] = q_H_10_im;
  assign qh_in_re[3] = q_H_11_re;
  assign qh_in_im[3] = q_H_11_im;

  assign qh_load_req = qh_valid & ~qh_valid_prev_q;
  assign y_xfer      = y_valid & y_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_qh
      logic signed [WIDTH-1:0] re_q, re_d, im_q, im_d;

      always_comb begin
        re_d = re_q;
        im_d = im_q;
        if (load_en) begin
          re_d = $signed(qh_in_re[gi]);
          im_d = $signed(qh_in_im[gi]);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          re_q <= '0;
          im_q <= '0;
        end else begin
          re_q <= re_d;
          im_q <= im_d;
        end
      end

      assign qh_re[gi] = re_q;
      assign qh_im[gi] = im_q;
    end
  endgenerate

  // Shared complex multiplier: cnt selects the Q^H entry, cnt[0] selects y0 or y1.
  assign a_re = qh_re[cnt_q];
  assign a_im = qh_im[cnt_q];
  assign b_re = cnt_q[0] ? y1_re_q : y0_re_q;
  assign b_im = cnt_q[0] ? y1_im_q : y0_im_q;

  assign p_ac = PW'(a_re) * PW'(b_re);
  assign p_bd = PW'(a_im) * PW'(b_im);
  assign p_ad = PW'(a_re) * PW'(b_im);
  assign p_bc = PW'(a_im) * PW'(b_re);

  assign prod_re = AW'(p_ac) - AW'(p_bd);
  assign prod_im = AW'(p_ad) + AW'(p_bc);

  // Round half up at the FRAC boundary, then clamp to the output range.
  function automatic logic signed [WIDTH-1:0] fmt(input logic signed [AW-1:0] x);
    logic signed [AW:0] r;
    logic signed [AW:0] rnd;
    logic signed [AW:0] smax;
    logic signed [AW:0] smin;
    rnd            = '0;
    rnd[FRAC-1]    = 1'b1;
    smax           = '0;
    smax[WIDTH-2:0] = '1;
    smin           = '1;
    smin[WIDTH-2:0] = '0;
    r = {x[AW-1], x} + rnd;
    r = r >>> FRAC;
    if (r > smax) begin
      fmt = smax[WIDTH-1:0];
    end else if (r < smin) begin
      fmt = smin[WIDTH-1:0];
    end else begin
      fmt = r[WIDTH-1:0];
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load_en) state_d = S_WAIT_Y0;
      S_WAIT_Y0: if (y_xfer) state_d = S_WAIT_Y1;
      S_WAIT_Y1: if (y_xfer) state_d = S_MAC;
      S_MAC:     if (cnt_q == 2'd3) state_d = S_OUT0;
      S_OUT0:    state_d = S_OUT1;
      S_OUT1:    state_d = S_WAIT_Y0;
      default:   state_d = S_IDLE;
    endcase
  end

  // A load in WAIT_Y0 (fresh or pending) blocks the input for that cycle.
  always_comb begin
    load_en = 1'b0;
    y_ready = 1'b0;
    case (state_q)
      S_IDLE: load_en = qh_load_req;
      S_WAIT_Y0: begin
        load_en = qh_load_req | pend_q;
        y_ready = ~(qh_load_req | pend_q);
      end
      S_WAIT_Y1: y_ready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    qh_valid_prev_d = qh_valid;
    pend_d          = pend_q;
    cnt_d           = cnt_q;
    y0_re_d         = y0_re_q;
    y0_im_d         = y0_im_q;
    y1_re_d         = y1_re_q;
    y1_im_d         = y1_im_q;
    acc0_re_d       = acc0_re_q;
    acc0_im_d       = acc0_im_q;
    acc1_re_d       = acc1_re_q;
    acc1_im_d       = acc1_im_q;
    z_re_d          = z_re_q;
    z_im_d          = z_im_q;
    z_idx_d         = z_idx_q;
    z_valid_d       = 1'b0;

    if (load_en) begin
      pend_d = 1'b0;
    end else if (qh_load_req) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_WAIT_Y0: begin
        if (y_xfer) begin
          y0_re_d = $signed(y_re);
          y0_im_d = $signed(y_im);
        end
      end
      S_WAIT_Y1: begin
        if (y_xfer) begin
          y1_re_d = $signed(y_re);
          y1_im_d = $signed(y_im);
          cnt_d   = 2'd0;
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + 2'd1;
        if (!cnt_q[1]) begin
          acc0_re_d = cnt_q[0] ? acc0_re_q + prod_re : prod_re;
          acc0_im_d = cnt_q[0] ? acc0_im_q + prod_im : prod_im;
        end else begin
          acc1_re_d = cnt_q[0] ? acc1_re_q + prod_re : prod_re;
          acc1_im_d = cnt_q[0] ? acc1_im_q + prod_im : prod_im;
        end
      end
      S_OUT0: begin
        z_re_d    = fmt(acc0_re_q);
        z_im_d    = fmt(acc0_im_q);
        z_idx_d   = 1'b0;
        z_valid_d = 1'b1;
      end
      S_OUT1: begin
        z_re_d    = fmt(acc1_re_q);
        z_im_d    = fmt(acc1_im_q);
        z_idx_d   = 1'b1;
        z_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qh_valid_prev_q <= 1'b0;
      pend_q          <= 1'b0;
      cnt_q           <= '0;
      y0_re_q         <= '0;
      y0_im_q         <= '0;
      y1_re_q         <= '0;
      y1_im_q         <= '0;
      acc0_re_q       <= '0;
      acc0_im_q       <= '0;
      acc1_re_q       <= '0;
      acc1_im_q       <= '0;
      z_re_q          <= '0;
      z_im_q          <= '0;
      z_idx_q         <= 1'b0;
      z_valid_q       <= 1'b0;
    end else begin
      qh_valid_prev_q <= qh_valid_prev_d;
      pend_q          <= pend_d;
      cnt_q           <= cnt_d;
      y0_re_q         <= y0_re_d;
      y0_im_q         <= y0_im_d;
      y1_re_q         <= y1_re_d;
      y1_im_q         <= y1_im_d;
      acc0_re_q       <= acc0_re_d;
      acc0_im_q       <= acc0_im_d;
      acc1_re_q       <= acc1_re_d;
      acc1_im_q       <= acc1_im_d;
      z_re_q          <= z_re_d;
      z_im_q          <= z_im_d;
      z_idx_q         <= z_idx_d;
      z_valid_q       <= z_valid_d;
    end
  end

  assign z_re    = z_re_q;
  assign z_im    = z_im_q;
  assign z_idx   = z_idx_q;
  assign z_valid = z_valid_q;

endmodule

// File: tb/tb_qhy_rotate.sv
// Scoreboard bench for qhy_rotate: directed test-plan vectors plus randomized
// matrices/vectors checked against a plain-arithmetic model of z = Q^H * y.
module tb_qhy_rotate;
  localparam int W = 16;
  localparam int F = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         qh_valid = 1'b0;
  logic [W-1:0] q_re [4];
  logic [W-1:0] q_im [4];
  logic [W-1:0] y_re, y_im;
  logic         y_valid = 1'b0;
  logic         y_ready;
  logic [W-1:0] z_re, z_im;
  logic         z_idx, z_valid;

  qhy_rotate #(.WIDTH(W), .FRAC(F)) dut (
    .clk(clk), .rst(rst), .qh_valid(qh_valid),
    .q_H_00_re(q_re[0]), .q_H_00_im(q_im[0]),
    .q_H_01_re(q_re[1]), .q_H_01_im(q_im[1]),
    .q_H_10_re(q_re[2]), .q_H_10_im(q_im[2]),
    .q_H_11_re(q_re[3]), .q_H_11_im(q_im[3]),
    .y_re(y_re), .y_im(y_im), .y_valid(y_valid), .y_ready(y_ready),
    .z_re(z_re), .z_im(z_im), .z_idx(z_idx), .z_valid(z_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Matrix currently presented on the ports (model view), entries q00,q01,q10,q11.
  int qm_re [4];
  int qm_im [4];
  int nq_re [4];
  int nq_im [4];

  typedef struct {
    int re;
    int im;
    int idx;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint fmt_m(input longint x);
    longint r;
    longint hi;
    longint lo;
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    r = (x + (longint'(1) << (F - 1))) >>> F;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && z_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_z: got z_valid=1 idx=%0d re=%0d expected no output", z_idx, $signed(z_re));
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] z%0d out re=%0d im=%0d (exp %0d,%0d) at cycle %0d", z_idx, $signed(z_re), $signed(z_im), mon_e.re, mon_e.im, cyc);
        chk("z_re", $signed(z_re), mon_e.re);
        chk("z_im", $signed(z_im), mon_e.im);
        chk("z_idx", z_idx, mon_e.idx);
        chk("z_latency", cyc, mon_e.cyc);
      end
    end
  end

  task automatic set_nq(input int r00, i00, r01, i01, r10, i10, r11, i11);
    nq_re[0] = r00; nq_im[0] = i00;
    nq_re[1] = r01; nq_im[1] = i01;
    nq_re[2] = r10; nq_im[2] = i10;
    nq_re[3] = r11; nq_im[3] = i11;
  endtask

  // Drop qh_valid for a cycle, then raise it with the new matrix on the ports.
  task automatic reload();
    @(negedge clk);
    qh_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      q_re[k] = W'(nq_re[k]);
      q_im[k] = W'(nq_im[k]);
    end
    qm_re = nq_re;
    qm_im = nq_im;
    qh_valid = 1'b1;
    $display("[TB] qh load q00=(%0d,%0d) q01=(%0d,%0d) q10=(%0d,%0d) q11=(%0d,%0d)",
             nq_re[0], nq_im[0], nq_re[1], nq_im[1], nq_re[2], nq_im[2], nq_re[3], nq_im[3]);
  endtask

  task automatic send_y(input int r, input int i, output int c);
    c = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      y_valid = 1'b1;
      y_re = W'(r);
      y_im = W'(i);
      #1;
      if (y_ready) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL y_accept: got no y_ready within 50 cycles expected acceptance");
    end else begin
      @(posedge clk);
    end
    #1 y_valid = 1'b0;
  endtask

  task automatic xfer_vec(input int y0r, y0i, y1r, y1i, input int gap, input bit push,
                          input bit use_model, input int x0r, x0i, x1r, x1i);
    int     sr [4];
    int     si [4];
    int     c0, c1;
    longint yr [2];
    longint yi [2];
    longint ar, ai;
    int     er [2];
    int     ei [2];
    send_y(y0r, y0i, c0);
    sr = qm_re;
    si = qm_im;
    repeat (gap) @(negedge clk);
    send_y(y1r, y1i, c1);
    $display("[TB] vector y0=(%0d,%0d) y1=(%0d,%0d) gap=%0d accepted cycle %0d", y0r, y0i, y1r, y1i, gap, c1);
    if (c0 < 0 || c1 < 0 || !push) return;
    if (use_model) begin
      yr[0] = y0r; yi[0] = y0i;
      yr[1] = y1r; yi[1] = y1i;
      for (int i = 0; i < 2; i++) begin
        ar = 0;
        ai = 0;
        for (int j = 0; j < 2; j++) begin
          ar += longint'(sr[2*i+j]) * yr[j] - longint'(si[2*i+j]) * yi[j];
          ai += longint'(sr[2*i+j]) * yi[j] + longint'(si[2*i+j]) * yr[j];
        end
        er[i] = int'(fmt_m(ar));
        ei[i] = int'(fmt_m(ai));
      end
    end else begin
      er[0] = x0r; ei[0] = x0i;
      er[1] = x1r; ei[1] = x1i;
    end
    sb.push_back('{er[0], ei[0], 0, c1 + 6});
    sb.push_back('{er[1], ei[1], 1, c1 + 7});
  endtask

  task automatic wait_z1();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (z_valid && z_idx) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_z1: got no z1 strobe within 30 cycles expected one");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      q_re[k] = '0;
      q_im[k] = '0;
      qm_re[k] = 0;
      qm_im[k] = 0;
    end
    y_re = '0;
    y_im = '0;

    repeat (3) @(negedge clk);
    chk("rst_y_ready", y_ready, 0);
    chk("rst_z_re", z_re, 0);
    chk("rst_z_im", z_im, 0);
    chk("rst_z_idx", z_idx, 0);
    chk("rst_z_valid", z_valid, 0);
    rst = 1'b0;

    // y_valid in IDLE must be ignored, including across the load edge
    y_valid = 1'b1;
    y_re = W'(77);
    y_im = W'(-77);
    repeat (3) begin
      @(negedge clk);
      #1 chk("idle_y_ready", y_ready, 0);
    end
    set_nq(256, 0, 0, 0, 0, 0, 256, 0);
    reload();
    #1 chk("load_cycle_y_ready", y_ready, 0);
    y_valid = 1'b0;
    @(negedge clk);
    #1 chk("post_load_y_ready", y_ready, 1);

    // identity
    xfer_vec(100, -50, 30, 7, 0, 1, 0, 100, -50, 30, 7);
    wait_z1();
    #1 chk("wait_y0_ready", y_ready, 1);

    // phase rotation, loaded with y_valid coincident on the load edge
    set_nq(0, 256, 0, 0, 0, 0, 256, 0);
    reload();
    y_valid = 1'b1;
    y_re = W'(999);
    y_im = W'(999);
    #1 chk("coincident_y_ready", y_ready, 0);
    xfer_vec(100, -50, 1, 1, 0, 1, 0, 50, 100, 1, 1);

    // rounding
    set_nq(128, 0, 0, 0, 0, 0, 0, 0);
    reload();
    xfer_vec(3, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
    xfer_vec(-3, 0, 0, 0, 1, 1, 0, -1, 0, 0, 0);

    // saturation
    set_nq(256, 0, 256, 0, 0, 0, 0, 0);
    reload();
    xfer_vec(20000, 0, 20000, 0, 0, 1, 0, 32767, 0, 0, 0);
    xfer_vec(-20000, 0, -20000, 0, 0, 1, 0, -32768, 0, 0, 0);

    // deferred reload raised during MAC
    set_nq(256, 0, 0, 0, 0, 0, 256, 0);
    reload();
    xfer_vec(11, -4, -7, 3, 0, 1, 0, 11, -4, -7, 3);
    set_nq(0, 0, 256, 0, 256, 0, 0, 0);
    reload();
    wait_z1();
    #1 chk("deferred_ready_low", y_ready, 0);
    @(negedge clk);
    #1 chk("deferred_ready_high", y_ready, 1);
    xfer_vec(5, 0, 9, 0, 0, 1, 0, 9, 0, 5, 0);

    // gap between y0 and y1
    xfer_vec(-123, 45, 67, -89, 3, 1, 0, 67, -89, -123, 45);

    // reset during MAC with qh_valid held high
    xfer_vec(500, 500, 600, 600, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_z_valid", z_valid, 0);
    chk("midrst_y_ready", y_ready, 0);
    chk("midrst_z_re", z_re, 0);
    @(negedge clk);
    rst = 1'b0;
    xfer_vec(1000, -2000, -300, 400, 0, 1, 0, -300, 400, 1000, -2000);

    // randomized matrices and vectors
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 4; k++) begin
          nq_re[k] = int'($urandom_range(0, 65535)) - 32768;
          nq_im[k] = int'($urandom_range(0, 65535)) - 32768;
        end
        reload();
      end
      xfer_vec(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 2)), 1, 1, 0, 0, 0, 0);
    end

    for (int t = 0; t < 100 && sb.size() > 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
